// File: rtl/pattern_detector.sv
// Serial pattern detector: shifts accepted bits into a LEN-bit history,
// raises a registered one-cycle match pulse and keeps a saturating count
// of matches that can be cleared synchronously.
//
// Input qualifier: seq_in is sampled only on rising edges where
// in_valid=1. There is no backpressure; every valid bit is consumed on the
// edge where it is presented.
module pattern_detector #(
  parameter int unsigned          LEN     = 4,
  parameter logic [LEN-1:0]       PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             in_valid,
  input  logic             clear_count,
  output logic             seq_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // Reject unsupported sizes at elaboration time.
  if (LEN < 2 || LEN > 16) begin : g_bad_len
    $error("pattern_detector: LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $error("pattern_detector: CNT_W must be in 1..16");
  end

  localparam int unsigned          FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  logic [LEN-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              seq_out_q, seq_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              match;
  logic [CNT_W-1:0]  cnt_base;

  // Next-state: shift history, track fill, detect match, update counter.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    match     = 1'b0;
    seq_out_d = 1'b0;
    cnt_base  = cnt_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;

    if (in_valid) begin
      hist_d = {hist_q[LEN-2:0], seq_in};
      fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      match  = (fill_d == FILL_FULL) && (hist_d == PATTERN);
      // Non-overlapping mode discards all bits consumed by this match.
      if (match && !OVERLAP) begin
        fill_d = '0;
      end
    end

    seq_out_d = match;

    // Clear is applied before the increment so a match on a clear edge counts as 1.
    cnt_base = clear_count ? '0 : cnt_q;
    cnt_d    = (match && (cnt_base != CNT_MAX)) ? cnt_base + CNT_W'(1) : cnt_base;
    sat_d    = (cnt_d == CNT_MAX);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      seq_out_q <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      seq_out_q <= seq_out_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign seq_out     = seq_out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: four instances with different parameter sets
// share one clock; each vector targets one instance.
module tb_pattern_detector;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst [4];
  logic       vin [4];
  logic       din [4];
  logic       clr [4];
  logic       out [4];
  logic       sat [4];
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;
  logic [9:0] act [4];

  // d0: defaults (overlap)
  pattern_detector u_d0 (
    .clock(clock), .reset(rst[0]), .seq_in(din[0]), .in_valid(vin[0]),
    .clear_count(clr[0]), .seq_out(out[0]), .match_count(cnt0), .count_sat(sat[0]));

  // d1: non-overlapping
  pattern_detector #(.OVERLAP(1'b0)) u_d1 (
    .clock(clock), .reset(rst[1]), .seq_in(din[1]), .in_valid(vin[1]),
    .clear_count(clr[1]), .seq_out(out[1]), .match_count(cnt1), .count_sat(sat[1]));

  // d2: 2-bit saturating counter
  pattern_detector #(.CNT_W(2)) u_d2 (
    .clock(clock), .reset(rst[2]), .seq_in(din[2]), .in_valid(vin[2]),
    .clear_count(clr[2]), .seq_out(out[2]), .match_count(cnt2), .count_sat(sat[2]));

  // d3: 6-bit pattern
  pattern_detector #(.LEN(6), .PATTERN(6'b110110)) u_d3 (
    .clock(clock), .reset(rst[3]), .seq_in(din[3]), .in_valid(vin[3]),
    .clear_count(clr[3]), .seq_out(out[3]), .match_count(cnt3), .count_sat(sat[3]));

  always_comb begin
    act[0] = {out[0], cnt0, sat[0]};
    act[1] = {out[1], cnt1, sat[1]};
    act[2] = {out[2], 6'b0, cnt2, sat[2]};
    act[3] = {out[3], cnt3, sat[3]};
  end

  // ---------------- vector table ----------------
  typedef struct {
    int         dut;
    logic       r, v, b, c;
    logic       eo;
    logic [7:0] ec;
    logic       es;
    string      name;
  } vec_t;

  vec_t       vecs [$];
  logic [9:0] exp_q [$];
  int         n_checks = 0;
  int         n_err    = 0;

  function automatic void add(int d, logic r, logic v, logic b, logic c,
                              logic eo, logic [7:0] ec, logic es, string n);
    vec_t t;
    t.dut = d; t.r = r; t.v = v; t.b = b; t.c = c;
    t.eo = eo; t.ec = ec; t.es = es; t.name = n;
    vecs.push_back(t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(int d, logic r, logic v, logic b, logic c);
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; vin[i] = 1'b0; din[i] = 1'b0; clr[i] = 1'b0;
    end
    rst[d] = r; vin[d] = v; din[d] = b; clr[d] = c;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_all();
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; vin[i] = 1'b0; din[i] = 1'b0; clr[i] = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(int d, string n);
    logic [9:0] e;
    e = exp_q.pop_front();
    n_checks++;
    if (act[d] !== e) begin
      n_err++;
      $display("FAIL %s: dut%0d got out=%0b cnt=%0d sat=%0b, expected out=%0b cnt=%0d sat=%0b",
               n, d, act[d][9], act[d][8:1], act[d][0], e[9], e[8:1], e[0]);
    end
  endtask

  task automatic expect_step(int d, logic r, logic v, logic b, logic c,
                             logic eo, logic [7:0] ec, logic es, string n);
    step(d, r, v, b, c);
    exp_q.push_back({eo, ec, es});
    check(d, n);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0] pat;
    logic [7:0] ec;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; vin[i] = 1'b0; din[i] = 1'b0; clr[i] = 1'b0;
    end

    // d0 overlap stream 1011011 -> pulses after bits 4 and 7
    add(0, 1,1,1,0, 0,0,0, "d0_reset");
    add(0, 0,1,1,0, 0,0,0, "d0_ov_b1");
    add(0, 0,1,0,0, 0,0,0, "d0_ov_b2");
    add(0, 0,1,1,0, 0,0,0, "d0_ov_b3");
    add(0, 0,1,1,0, 1,1,0, "d0_ov_b4");
    add(0, 0,1,0,0, 0,1,0, "d0_ov_b5");
    add(0, 0,1,1,0, 0,1,0, "d0_ov_b6");
    add(0, 0,1,1,0, 1,2,0, "d0_ov_b7");
    add(0, 0,0,0,1, 0,0,0, "d0_clear_nomatch");
    // d0 gaps between bits: single pulse, no stretch during gaps
    add(0, 1,0,0,0, 0,0,0, "d0_gap_reset");
    add(0, 0,1,1,0, 0,0,0, "d0_gap_b1");
    add(0, 0,0,1,0, 0,0,0, "d0_gap_idle1");
    add(0, 0,1,0,0, 0,0,0, "d0_gap_b2");
    add(0, 0,0,1,0, 0,0,0, "d0_gap_idle2");
    add(0, 0,1,1,0, 0,0,0, "d0_gap_b3");
    add(0, 0,0,0,0, 0,0,0, "d0_gap_idle3");
    add(0, 0,1,1,0, 1,1,0, "d0_gap_b4");
    add(0, 0,0,1,0, 0,1,0, "d0_gap_nostretch");
    add(0, 0,0,1,0, 0,1,0, "d0_gap_idle5");
    // d0 reset mid-pattern; bit on reset edge discarded
    add(0, 0,1,1,0, 0,1,0, "d0_mid_b1");
    add(0, 0,1,0,0, 0,1,0, "d0_mid_b2");
    add(0, 0,1,1,0, 0,1,0, "d0_mid_b3");
    add(0, 1,1,1,1, 0,0,0, "d0_mid_reset");
    add(0, 0,1,1,0, 0,0,0, "d0_mid_after1");
    add(0, 0,1,0,0, 0,0,0, "d0_mid_after2");
    add(0, 0,1,1,0, 0,0,0, "d0_mid_after3");
    add(0, 0,1,1,0, 1,1,0, "d0_mid_after4");
    // d1 non-overlap: 1011011 -> one pulse
    add(1, 1,0,0,0, 0,0,0, "d1_reset");
    add(1, 0,1,1,0, 0,0,0, "d1_a_b1");
    add(1, 0,1,0,0, 0,0,0, "d1_a_b2");
    add(1, 0,1,1,0, 0,0,0, "d1_a_b3");
    add(1, 0,1,1,0, 1,1,0, "d1_a_b4");
    add(1, 0,1,0,0, 0,1,0, "d1_a_b5");
    add(1, 0,1,1,0, 0,1,0, "d1_a_b6");
    add(1, 0,1,1,0, 0,1,0, "d1_a_b7");
    // d1 non-overlap: 10111011 -> pulses after 4 and 8
    add(1, 1,0,0,0, 0,0,0, "d1_reset2");
    add(1, 0,1,1,0, 0,0,0, "d1_b_b1");
    add(1, 0,1,0,0, 0,0,0, "d1_b_b2");
    add(1, 0,1,1,0, 0,0,0, "d1_b_b3");
    add(1, 0,1,1,0, 1,1,0, "d1_b_b4");
    add(1, 0,1,1,0, 0,1,0, "d1_b_b5");
    add(1, 0,1,0,0, 0,1,0, "d1_b_b6");
    add(1, 0,1,1,0, 0,1,0, "d1_b_b7");
    add(1, 0,1,1,0, 1,2,0, "d1_b_b8");
    // d3 LEN=6 overlap: 110110110 -> pulses after 6 and 9
    add(3, 1,0,0,0, 0,0,0, "d3_reset");
    add(3, 0,1,1,0, 0,0,0, "d3_b1");
    add(3, 0,1,1,0, 0,0,0, "d3_b2");
    add(3, 0,1,0,0, 0,0,0, "d3_b3");
    add(3, 0,1,1,0, 0,0,0, "d3_b4");
    add(3, 0,1,1,0, 0,0,0, "d3_b5");
    add(3, 0,1,0,0, 1,1,0, "d3_b6");
    add(3, 0,1,1,0, 0,1,0, "d3_b7");
    add(3, 0,1,1,0, 0,1,0, "d3_b8");
    add(3, 0,1,0,0, 1,2,0, "d3_b9");

    reset_all();

    foreach (vecs[k]) begin
      step(vecs[k].dut, vecs[k].r, vecs[k].v, vecs[k].b, vecs[k].c);
      exp_q.push_back({vecs[k].eo, vecs[k].ec, vecs[k].es});
      check(vecs[k].dut, vecs[k].name);
    end

    // d2 CNT_W=2: five back-to-back matches saturate at 3
    pat = 4'b1011;
    expect_step(2, 1,0,0,0, 0,0,0, "d2_reset");
    for (int m = 1; m <= 5; m++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) ec = (m > 3) ? 8'd3 : 8'(m);
        else        ec = (m - 1 > 3) ? 8'd3 : 8'(m - 1);
        expect_step(2, 0, 1, pat[3-j], 0, (j == 3), ec, (ec == 8'd3),
                    $sformatf("d2_sat_m%0d_b%0d", m, j));
      end
    end
    // clear coinciding with a match: count restarts at 1, pulse still fires
    expect_step(2, 0,1,1,0, 0,3,1, "d2_clr_b1");
    expect_step(2, 0,1,0,0, 0,3,1, "d2_clr_b2");
    expect_step(2, 0,1,1,0, 0,3,1, "d2_clr_b3");
    expect_step(2, 0,1,1,1, 1,1,0, "d2_clr_on_match");
    expect_step(2, 0,0,0,1, 0,0,0, "d2_clr_plain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
